// File: rtl/envolve_fill_sequencer_pkg.sv
// envolve_fill_sequencer_pkg: shared constants, state encoding and helpers for
// the cell-map fill sequencer. The glider stamp (PATTERN state) exists only
// when FILL_PATTERN_EN is defined.
package envolve_fill_sequencer_pkg;

    // Map address width; covers maps up to 256 x 256.
    localparam int ADDR_WIDTH = 8;

    // Random-fill LFSR reset value (must be non-zero).
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

    // Number of cells written by one glider stamp.
    localparam int GLIDER_LEN = 5;

`ifdef FILL_PATTERN_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RANDOM  = 3'd2,
        S_PATTERN = 3'd3,
        S_DONE    = 3'd4
    } fill_state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RANDOM  = 3'd2,
        S_DONE    = 3'd4
    } fill_state_e;
`endif

    // Glider row offsets, in write order: (0,1),(1,2),(2,0),(2,1),(2,2).
    function automatic logic [1:0] glider_dy(input logic [2:0] idx);
        case (idx)
            3'd0:    return 2'd0;
            3'd1:    return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    // Glider column offsets, same order as glider_dy.
    function automatic logic [1:0] glider_dx(input logic [2:0] idx);
        case (idx)
            3'd0:    return 2'd1;
            3'd1:    return 2'd2;
            3'd2:    return 2'd0;
            3'd3:    return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    // (base + off) mod lim by compare-and-subtract; valid because base < lim,
    // off <= 2 and lim >= 2, so the sum never reaches 2*lim.
    function automatic logic [ADDR_WIDTH-1:0] wrap_add(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [1:0]            off,
        input logic [ADDR_WIDTH:0]   lim
    );
        logic [ADDR_WIDTH:0] sum;
        sum = {1'b0, base} + {{(ADDR_WIDTH-1){1'b0}}, off};
        if (sum >= lim) begin
            sum = sum - lim;
        end
        return sum[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/envolve_fill_sequencer_if.sv
// envolve_fill_sequencer_if: command side and map write port of the fill
// sequencer. master = command decoder / map side, slave = the sequencer.
interface envolve_fill_sequencer_if;
    import envolve_fill_sequencer_pkg::*;

    logic                  mode;
    logic                  cmd_clear;
    logic                  cmd_random;
    logic                  cmd_pattern;
    logic [ADDR_WIDTH-1:0] cur_x;
    logic [ADDR_WIDTH-1:0] cur_y;
    logic                  edit_req;
    logic                  edit_data;
    logic                  edit_ack;
    logic [ADDR_WIDTH-1:0] wAddrR;
    logic [ADDR_WIDTH-1:0] wAddrC;
    logic                  write_en;
    logic                  write_data;
    logic                  busy;
    logic                  done;

    modport master (
        output mode, cmd_clear, cmd_random, cmd_pattern, cur_x, cur_y,
               edit_req, edit_data,
        input  edit_ack, wAddrR, wAddrC, write_en, write_data, busy, done
    );

    modport slave (
        input  mode, cmd_clear, cmd_random, cmd_pattern, cur_x, cur_y,
               edit_req, edit_data,
        output edit_ack, wAddrR, wAddrC, write_en, write_data, busy, done
    );

endinterface

// File: rtl/envolve_fill_sequencer_fill_lfsr16.sv
// envolve_fill_sequencer_fill_lfsr16: free-running 16-bit Fibonacci LFSR
// (taps 16,14,13,11) feeding the random fill. Advances every clock.
module envolve_fill_sequencer_fill_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic feedback;

    // Taps 16,14,13,11 map to bits 0,2,3,5 of a right-shifting register.
    assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];

    // Shift right every cycle, feedback enters at the top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else begin
            state <= {feedback, state[15:1]};
        end
    end

endmodule

// File: rtl/envolve_fill_sequencer.sv
// envolve_fill_sequencer: owns the cell map's single write port in edit mode
// and serialises bulk clear, random fill, glider stamp and cursor edits onto
// it, one write per clock. Optional macro FILL_PATTERN_EN enables the glider
// stamp; without it cmd_pattern is ignored.
module envolve_fill_sequencer
    import envolve_fill_sequencer_pkg::*;
#(
    parameter int unsigned MAP_WIDTH  = 8,
    parameter int unsigned MAP_HEIGHT = 8,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_LFSR_SEED
) (
    input  logic                   clk,
    input  logic                   rst,
    envolve_fill_sequencer_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(MAP_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(MAP_HEIGHT - 1);

    fill_state_e state;
    logic [15:0] lfsr_state;
    logic        unused_lfsr_hi;
    logic        sweep_last;

    envolve_fill_sequencer_fill_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    // Only bit 0 drives the fill data.
    assign unused_lfsr_hi = ^lfsr_state[15:1];

    // The write address registers double as the sweep counters.
    assign sweep_last = (bus.wAddrR == LAST_ROW) && (bus.wAddrC == LAST_COL);

`ifdef FILL_PATTERN_EN
    localparam logic [ADDR_WIDTH:0] COL_LIM = (ADDR_WIDTH+1)'(MAP_WIDTH);
    localparam logic [ADDR_WIDTH:0] ROW_LIM = (ADDR_WIDTH+1)'(MAP_HEIGHT);

    logic [2:0]            glider_idx;
    logic [2:0]            glider_nxt;
    logic [ADDR_WIDTH-1:0] anchor_x;
    logic [ADDR_WIDTH-1:0] anchor_y;

    assign glider_nxt = glider_idx + 3'd1;
`else
    logic unused_cmd_pattern;
    assign unused_cmd_pattern = bus.cmd_pattern;
`endif

    // Sequencer FSM: arbitrates in IDLE, runs sweeps/stamps, all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            bus.write_en   <= 1'b0;
            bus.write_data <= 1'b0;
            bus.wAddrR     <= '0;
            bus.wAddrC     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.edit_ack   <= 1'b0;
`ifdef FILL_PATTERN_EN
            glider_idx     <= '0;
            anchor_x       <= '0;
            anchor_y       <= '0;
`endif
        end else if (bus.mode) begin
            // Run mode takes the map: abandon any operation silently.
            state        <= S_IDLE;
            bus.write_en <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.edit_ack <= 1'b0;
        end else begin
            bus.write_en <= 1'b0;
            bus.edit_ack <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_clear) begin
                        state          <= S_CLEAR;
                        bus.wAddrR     <= '0;
                        bus.wAddrC     <= '0;
                        bus.write_data <= 1'b0;
                        bus.write_en   <= 1'b1;
                        bus.busy       <= 1'b1;
                    end else if (bus.cmd_random) begin
                        state          <= S_RANDOM;
                        bus.wAddrR     <= '0;
                        bus.wAddrC     <= '0;
                        bus.write_data <= lfsr_state[0];
                        bus.write_en   <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
`ifdef FILL_PATTERN_EN
                    else if (bus.cmd_pattern) begin
                        // Cursor is latched so it may move during the stamp.
                        state          <= S_PATTERN;
                        anchor_x       <= bus.cur_x;
                        anchor_y       <= bus.cur_y;
                        glider_idx     <= 3'd0;
                        bus.wAddrR     <= wrap_add(bus.cur_y, glider_dy(3'd0), ROW_LIM);
                        bus.wAddrC     <= wrap_add(bus.cur_x, glider_dx(3'd0), COL_LIM);
                        bus.write_data <= 1'b1;
                        bus.write_en   <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
`endif
                    else if (bus.edit_req) begin
                        bus.wAddrR     <= bus.cur_y;
                        bus.wAddrC     <= bus.cur_x;
                        bus.write_data <= bus.edit_data;
                        bus.write_en   <= 1'b1;
                        bus.edit_ack   <= 1'b1;
                    end
                end

                S_CLEAR, S_RANDOM: begin
                    if (sweep_last) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        bus.write_en   <= 1'b1;
                        bus.write_data <= (state == S_RANDOM) ? lfsr_state[0] : 1'b0;
                        if (bus.wAddrC == LAST_COL) begin
                            bus.wAddrC <= '0;
                            bus.wAddrR <= bus.wAddrR + ADDR_WIDTH'(1);
                        end else begin
                            bus.wAddrC <= bus.wAddrC + ADDR_WIDTH'(1);
                        end
                    end
                end

`ifdef FILL_PATTERN_EN
                S_PATTERN: begin
                    if (glider_idx == 3'(GLIDER_LEN - 1)) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        glider_idx     <= glider_nxt;
                        bus.wAddrR     <= wrap_add(anchor_y, glider_dy(glider_nxt), ROW_LIM);
                        bus.wAddrC     <= wrap_add(anchor_x, glider_dx(glider_nxt), COL_LIM);
                        bus.write_data <= 1'b1;
                        bus.write_en   <= 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_envolve_fill_sequencer.sv
// tb_envolve_fill_sequencer: scoreboard bench for the fill sequencer. Stimulus
// pushes predicted writes/done pulses (with their cycle) into a queue; a
// negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_envolve_fill_sequencer;
    import envolve_fill_sequencer_pkg::*;

    localparam int W = 8;
    localparam int H = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int cyc;
        bit is_done;
        int row;
        int col;
        bit data;
        bit ack;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    logic [15:0] lfsr_m;
    exp_t exp_q[$];

    envolve_fill_sequencer_if bus();

    envolve_fill_sequencer #(
        .MAP_WIDTH  (W),
        .MAP_HEIGHT (H),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR built from the tap list, stepped once per clock.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int   taps[4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb = 1'b0;
        foreach (taps[i]) fb ^= v[16 - taps[i]];
        return {fb, v[15:1]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= SEED;
        else      lfsr_m <= lfsr_next(lfsr_m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        checks++;
        failures++;
        $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_wr(input int c, input int r, input int col, input bit d, input bit ack);
        exp_t e;
        e.cyc = c; e.is_done = 1'b0; e.row = r; e.col = col; e.data = d; e.ack = ack;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c);
        exp_t e;
        e.cyc = c; e.is_done = 1'b1; e.row = 0; e.col = 0; e.data = 1'b0; e.ack = 1'b0;
        exp_q.push_back(e);
    endtask

    // Row-major sweep from (0,0); write k lands at n+k carrying the LFSR bit
    // of cycle n+k-1 for a random fill.
    task automatic push_sweep(input int n, input bit rnd, input int nw, input bit with_done);
        logic [15:0] v;
        v = lfsr_m;
        for (int k = 1; k <= nw; k++) begin
            push_wr(n + k, (k - 1) / W, (k - 1) % W, rnd ? v[0] : 1'b0, 1'b0);
            v = lfsr_next(v);
        end
        if (with_done) push_done(n + W * H + 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_write_en"},   32'(bus.write_en),   32'd0);
        chk({tag, "_write_data"}, 32'(bus.write_data), 32'd0);
        chk({tag, "_wAddrR"},     32'(bus.wAddrR),     32'd0);
        chk({tag, "_wAddrC"},     32'(bus.wAddrC),     32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_done"},       32'(bus.done),       32'd0);
        chk({tag, "_edit_ack"},   32'(bus.edit_ack),   32'd0);
    endtask

    // Clear or random sweep; optional abort via mode at write abort_at, and
    // optional pokes of commands while busy and during the done cycle.
    task automatic run_sweep(input bit rnd, input int abort_at, input bit poke);
        int n;
        int nw;
        n  = cyc;
        nw = (abort_at > 0) ? abort_at : W * H;
        push_sweep(n, rnd, nw, abort_at == 0);
        busy_lo = n + 1;
        busy_hi = n + nw;
        if (rnd) bus.cmd_random = 1'b1; else bus.cmd_clear = 1'b1;
        tick();
        bus.cmd_random = 1'b0;
        bus.cmd_clear  = 1'b0;
        if (poke) begin
            while (cyc < n + 10) tick();
            bus.cmd_random  = 1'b1;
            bus.cmd_pattern = 1'b1;
            tick();
            bus.cmd_random  = 1'b0;
            bus.cmd_pattern = 1'b0;
        end
        if (abort_at > 0) begin
            while (cyc < n + abort_at) tick();
            bus.mode = 1'b1;
            tick();
            tick();
            bus.cmd_clear = 1'b1;
            bus.edit_req  = 1'b1;
            tick();
            bus.cmd_clear = 1'b0;
            bus.edit_req  = 1'b0;
            repeat (3) tick();
            bus.mode = 1'b0;
            tick();
        end else begin
            while (cyc < n + W * H + 1) tick();
            if (poke) begin
                bus.cmd_clear = 1'b1;
                tick();
                bus.cmd_clear = 1'b0;
            end else begin
                tick();
            end
        end
        chk("sweep_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_pattern(input int x, input int y);
        int n;
        int dy[5];
        int dx[5];
        n  = cyc;
        dy = '{0, 1, 2, 2, 2};
        dx = '{1, 2, 0, 1, 2};
`ifdef FILL_PATTERN_EN
        for (int i = 0; i < 5; i++) push_wr(n + 1 + i, (y + dy[i]) % H, (x + dx[i]) % W, 1'b1, 1'b0);
        push_done(n + 6);
        busy_lo = n + 1;
        busy_hi = n + 5;
`endif
        bus.cur_x = 8'(x);
        bus.cur_y = 8'(y);
        bus.cmd_pattern = 1'b1;
        tick();
        bus.cmd_pattern = 1'b0;
        bus.cur_x = 8'($urandom_range(0, W - 1));
        bus.cur_y = 8'($urandom_range(0, H - 1));
        while (cyc < n + 7) tick();
        chk("pattern_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_edit(input int x, input int y, input bit d, input int hold);
        int n;
        n = cyc;
        for (int k = 1; k <= hold; k++) push_wr(n + k, y, x, d, 1'b1);
        bus.cur_x     = 8'(x);
        bus.cur_y     = 8'(y);
        bus.edit_data = d;
        bus.edit_req  = 1'b1;
        repeat (hold) tick();
        bus.edit_req = 1'b0;
        tick();
        tick();
        chk("edit_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Clear and edit in the same cycle: sweep first, edit once back in IDLE.
    task automatic clear_with_edit(input int x, input int y, input bit d);
        int n;
        int t;
        n = cyc;
        push_sweep(n, 1'b0, W * H, 1'b1);
        push_wr(n + W * H + 3, y, x, d, 1'b1);
        busy_lo = n + 1;
        busy_hi = n + W * H;
        bus.cur_x     = 8'(x);
        bus.cur_y     = 8'(y);
        bus.edit_data = d;
        bus.edit_req  = 1'b1;
        bus.cmd_clear = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
        t = 0;
        while (bus.edit_ack !== 1'b1 && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) fail_now("edit_ack_timeout", t, 500);
        bus.edit_req = 1'b0;
        tick();
        chk("clear_edit_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_mid(input int k);
        int n;
        n = cyc;
        push_sweep(n, 1'b0, k, 1'b0);
        busy_lo = n + 1;
        busy_hi = n + k;
        bus.cmd_clear = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
        while (cyc < n + k) tick();
        rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midreset_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare each DUT write/done against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1) begin
            chk("busy", 32'(bus.busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (bus.write_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        fail_now("write_instead_of_done", cyc, e.cyc);
                    end else begin
                        chk("write_cycle", 32'(cyc),            32'(e.cyc));
                        chk("write_row",   32'(bus.wAddrR),     32'(e.row));
                        chk("write_col",   32'(bus.wAddrC),     32'(e.col));
                        chk("write_data",  32'(bus.write_data), 32'(e.data));
                        chk("edit_ack",    32'(bus.edit_ack),   32'(e.ack));
                    end
                end
            end else if (bus.edit_ack !== 1'b0) begin
                fail_now("stray_edit_ack", 1, 0);
            end
            if (bus.done !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_done) begin
                        fail_now("done_instead_of_write", cyc, e.cyc);
                    end else begin
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.mode        = 1'b0;
        bus.cmd_clear   = 1'b0;
        bus.cmd_random  = 1'b0;
        bus.cmd_pattern = 1'b0;
        bus.cur_x       = '0;
        bus.cur_y       = '0;
        bus.edit_req    = 1'b0;
        bus.edit_data   = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();

        run_sweep(1'b0, 0, 1'b1);
        run_sweep(1'b1, 0, 1'b0);
        do_pattern(6, 7);
        clear_with_edit(3, 5, 1'b1);
        do_edit(2, 4, 1'b1, 1);
        do_edit(7, 0, 1'b0, 3);
        run_sweep(1'b0, 20, 1'b0);
        reset_mid(30);
        run_sweep(1'b0, 0, 1'b0);

        repeat (12) begin
            int op;
            int x;
            int y;
            op = $urandom_range(0, 3);
            x  = $urandom_range(0, W - 1);
            y  = $urandom_range(0, H - 1);
            case (op)
                0:       do_edit(x, y, 1'($urandom_range(0, 1)), 1);
                1:       do_pattern(x, y);
                2:       run_sweep(1'b1, 0, 1'b0);
                default: do_edit(x, y, 1'($urandom_range(0, 1)), $urandom_range(2, 4));
            endcase
        end

        repeat (4) tick();
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/envolve_fill_sequencer.md
# envolve_fill_sequencer

Write-port sequencer for the cell map of the evolve sub-system. It owns the map's single write port (wAddrR/wAddrC/write_en/write_data) in edit mode and serialises the sources onto it: bulk clear, random fill, glider pattern stamp and single-cell cursor edits. It sits between the keyboard/button command decoder and envolve_logic, one write per clock.

## Interface
Parameters:
- MAP_WIDTH, 8, columns in map (2..256)
- MAP_HEIGHT, 8, rows in map (2..256)
- LFSR_SEED, 16'hACE1, random-fill LFSR reset value (non-zero)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- mode  in  1  0 = edit, 1 = evolve/run
- cmd_clear  in  1  single-cycle request: write 0 to every cell
- cmd_random  in  1  single-cycle request: write LFSR bit to every cell
- cmd_pattern  in  1  single-cycle request: stamp glider at cursor
- cur_x, cur_y  in  `ADDR_WIDTH  cursor column/row (< MAP_WIDTH/MAP_HEIGHT)
- edit_req  in  1  level request to write edit_data at cursor
- edit_data  in  1  value for cursor edit
- edit_ack  out  1  one-cycle pulse, coincides with the edit write
- wAddrR, wAddrC  out  `ADDR_WIDTH  write row/column
- write_en  out  1  write strobe
- write_data  out  1  cell value
- busy  out  1  sweep/stamp in progress
- done  out  1  one-cycle pulse after last write of a completed operation

## Operation
- States: IDLE, CLEAR, RANDOM, PATTERN, DONE.
- IDLE, mode=0: priority cmd_clear > cmd_random > cmd_pattern > edit_req. Winner chosen on the sampled cycle; losing command pulses are dropped; losing edit_req stays pending.
- CLEAR/RANDOM: row-major sweep, col increments 0..MAP_WIDTH-1, then row increments; one write per cycle; data 0 (CLEAR) or lfsr[0] (RANDOM). After (MAP_HEIGHT-1, MAP_WIDTH-1) -> DONE.
- PATTERN: 5 writes, data 1, offsets (dy,dx) in order (0,1),(1,2),(2,0),(2,1),(2,2); address = (cur_y+dy) mod MAP_HEIGHT, (cur_x+dx) mod MAP_WIDTH (compare-and-subtract, no divider). Cursor latched at start.
- DONE: done=1 for one cycle, -> IDLE.
- Edit: in IDLE, one write of edit_data at (cur_y, cur_x) with edit_ack; stays IDLE. A held edit_req produces one write per cycle (requester drops it on ack).
- Commands and edit_req arriving while busy are ignored (commands) or stalled (edit, no ack).
- mode=1 at any time: abort to IDLE next cycle, write_en=0, no done; all requests ignored while mode=1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock regardless of state.

## Timing
- All outputs registered. Reset: write_en 0, write_data 0, wAddrR/wAddrC 0, busy 0, done 0, edit_ack 0, state IDLE, lfsr LFSR_SEED.
- Command sampled at cycle N: first write at N+1 address (0,0); busy high N+1..N+W*H; last write at N+W*H; done at N+W*H+1; new command accepted from N+W*H+2.
- Pattern sampled at N: writes N+1..N+5, done N+6.
- Edit sampled at N: write_en and edit_ack at N+1.
- Reset mid-sweep: outputs to reset values immediately (async); partially written map is left as is.

## Configuration
- FILL_PATTERN_EN defined: PATTERN state and cmd_pattern path present as above.
- Undefined: cmd_pattern ignored (port kept, unused); state machine has no PATTERN state; all other behaviour identical.

## Structure
- Shared defines file: `ADDR_WIDTH, state encodings, glider offset constants, default LFSR seed.
- Sub-module fill_lfsr16 (clk, rst, seed parameter, 16-bit state out); sequencer is the rest.

## Test plan
- Reset then cmd_clear at cycle 10 (8x8): 64 writes, data 0, addresses (0,0)..(7,7) row-major at cycles 11..74, done at 75, busy 11..74.
- cmd_random: 64 writes whose data matches a reference LFSR from 16'hACE1 advanced per clock; done once.
- cursor (6,7), cmd_pattern: writes (7,7),(0,0),(1,6),(1,7),(1,0) with data 1, done 6 cycles after command; without FILL_PATTERN_EN no write, no done.
- cmd_clear and edit_req same cycle: sweep first, edit write+ack at cursor cycle after done returns to IDLE.
- mode raised at sweep write 20: write_en low next cycle, no done, busy 0; subsequent cmd_clear with mode=1 ignored.
- rst asserted mid-sweep: all outputs 0 asynchronously; after release, cmd_clear restarts from (0,0).
